// File: rtl/mem_dump_unit.sv
// Dumps data memory word by word, MSB byte first, through a start/done TX handshake.
// Optional MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte after the last data byte.
module mem_dump_unit #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 32,
  parameter int unsigned BYTE_WIDTH = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  output logic [DATA_WIDTH-1:0] o_mem_address,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  output logic [BYTE_WIDTH-1:0] o_tx_data,
  output logic                  o_tx_start,
  input  logic                  i_tx_done,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int unsigned CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0]      LAST_BYTE = CNT_W'(BYTES - 1);
  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(MEM_DEPTH - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, READ, SEND, WAIT, CKSUM, CKSUM_WAIT, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, READ, SEND, WAIT, DONE} state_t;
`endif

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   word_q, word_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [BYTE_WIDTH-1:0]   top_byte;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [BYTE_WIDTH-1:0]   cksum_q, cksum_d;
`endif

  assign top_byte      = word_q[DATA_WIDTH-1 -: BYTE_WIDTH];
  assign o_tx_data     = top_byte;
  assign o_mem_address = addr_q;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state and datapath next values
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    cksum_d = cksum_q;
`endif
    case (state_q)
      IDLE: begin
        if (i_start) begin
          addr_d  = '0;
`ifdef MEM_DUMP_CHECKSUM_EN
          cksum_d = '0;
`endif
          state_d = READ;
        end
      end
      READ: begin
        word_d  = i_mem_data;
        cnt_d   = '0;
        state_d = SEND;
      end
      SEND: begin
`ifdef MEM_DUMP_CHECKSUM_EN
        cksum_d = cksum_q ^ top_byte;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          if (cnt_q != LAST_BYTE) begin
            word_d  = word_q << BYTE_WIDTH;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = SEND;
          end else if (addr_q < LAST_ADDR) begin
            addr_d  = addr_q + DATA_WIDTH'(1);
            state_d = READ;
          end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
            // Checksum rides out through the word register's top byte
            word_d  = DATA_WIDTH'(cksum_q) << (DATA_WIDTH - BYTE_WIDTH);
            state_d = CKSUM;
`else
            state_d = DONE;
`endif
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CKSUM:      state_d = CKSUM_WAIT;
      CKSUM_WAIT: if (i_tx_done) state_d = DONE;
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath registers
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_q <= '0;
`endif
    end else begin
      addr_q  <= addr_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      cksum_q <= cksum_d;
`endif
    end
  end

  // Registered status outputs, aligned with the state they describe
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_tx_start <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
`ifdef MEM_DUMP_CHECKSUM_EN
      o_tx_start <= (state_d == SEND) || (state_d == CKSUM);
`else
      o_tx_start <= (state_d == SEND);
`endif
      o_busy     <= (state_d != IDLE);
      o_done     <= (state_d == DONE);
    end
  end

endmodule

// File: tb/tb_mem_dump_unit.sv
// Self-checking bench for mem_dump_unit: table-driven dumps plus reset, spurious-input and back-to-back sequences.
module tb_mem_dump_unit;
  localparam int unsigned DW = 32;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned BW = 8;
`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int NBT = 9;
`else
  localparam int NBT = 8;
`endif

  logic          clk = 1'b0;
  logic          rst, start, tx_done_m, spur_done, tx_done;
  logic [DW-1:0] mem_addr, mem_data;
  logic [BW-1:0] tx_data;
  logic          tx_start, busy, done;
  logic [DW-1:0] mem [DEPTH];

  int n_checks = 0;
  int n_fail = 0;
  int tx_delay = 3;
  int cyc = 0;
  int done_cnt = 0;
  logic [7:0] log_b[$];
  int         log_c[$];

  typedef struct {
    logic [31:0] w0;
    logic [31:0] w1;
    int          delay;
    logic [63:0] exp;
    logic [7:0]  cks;
    int          per_in;
    int          per_x;
  } vec_t;
  vec_t vecs[4];

  always #5 clk = ~clk;
  assign tx_done  = tx_done_m | spur_done;
  assign mem_data = (mem_addr < DW'(DEPTH)) ? mem[mem_addr[0]] : '0;

  mem_dump_unit #(.DATA_WIDTH(DW), .MEM_DEPTH(DEPTH), .BYTE_WIDTH(BW)) dut (
    .i_clock(clk), .i_reset(rst), .i_start(start),
    .o_mem_address(mem_addr), .i_mem_data(mem_data),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_done(tx_done),
    .o_busy(busy), .o_done(done)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // TX model: done pulse tx_delay cycles after a start, checks byte stability while waiting
  initial begin
    bit pend;
    int cnt;
    logic [7:0] hold;
    pend = 0; cnt = 0; hold = '0;
    tx_done_m = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_m = 1'b0;
      if (rst) pend = 0;
      else begin
        if (pend) begin
          chk("tx_data_stable", 64'(tx_data), 64'(hold));
          if (cnt <= 1) begin tx_done_m = 1'b1; pend = 0; end
          else cnt--;
        end
        if (tx_start) begin pend = 1; cnt = tx_delay; hold = tx_data; end
      end
    end
  end

  // Byte and done logger
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (tx_start) begin log_b.push_back(tx_data); log_c.push_back(cyc); end
      if (done) done_cnt++;
    end
  end

  task automatic clear_logs();
    log_b.delete();
    log_c.delete();
    done_cnt = 0;
  endtask

  task automatic wait_done(input int limit, output bit got);
    got = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (done) begin got = 1; break; end
    end
  endtask

  task automatic do_dump(input string tag);
    bit got;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    chk({tag, "_busy_read"}, 64'(busy), 64'd1);
    chk({tag, "_addr_read"}, 64'(mem_addr), 64'd0);
    chk({tag, "_start_read"}, 64'(tx_start), 64'd0);
    @(negedge clk);
    chk({tag, "_start_first"}, 64'(tx_start), 64'd1);
    wait_done(400, got);
    chk({tag, "_done_seen"}, 64'(got), 64'd1);
    chk({tag, "_busy_at_done"}, 64'(busy), 64'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busy), 64'd0);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_addr_hold"}, 64'(mem_addr), 64'(DEPTH - 1));
    @(negedge clk);
    chk({tag, "_done_count"}, 64'(done_cnt), 64'd1);
  endtask

  task automatic check_seq(input string tag, input logic [63:0] exp, input logic [7:0] cks, input int reps);
    logic [63:0] e;
    chk({tag, "_byte_count"}, 64'(log_b.size()), 64'(reps * NBT));
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < NBT; i++) begin
        int idx;
        idx = r * NBT + i;
        e = exp;
        if (idx < log_b.size())
          chk($sformatf("%s_byte%0d", tag, idx), 64'(log_b[idx]),
              (i < 8) ? 64'(e[63 - 8*i -: 8]) : 64'(cks));
      end
    end
  endtask

  initial begin
    bit found;
    vecs[0] = '{32'h12345678, 32'hCAFEBABE, 3, 64'h12345678_CAFEBABE, 8'h38, 4, 5};
    vecs[1] = '{32'h12345678, 32'hCAFEBABE, 1, 64'h12345678_CAFEBABE, 8'h38, 2, 3};
    vecs[2] = '{32'h00000000, 32'hFFFFFFFF, 2, 64'h00000000_FFFFFFFF, 8'h00, 3, 4};
    vecs[3] = '{32'hA5A55A5A, 32'h01020304, 5, 64'hA5A55A5A_01020304, 8'h04, 6, 7};

    rst = 1'b1; start = 1'b0; spur_done = 1'b0;
    mem[0] = 32'h12345678; mem[1] = 32'hCAFEBABE;
    repeat (2) @(negedge clk);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    chk("rst_tx_data", 64'(tx_data), 64'd0);
    chk("rst_tx_start", 64'(tx_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 4; v++) begin
      mem[0] = vecs[v].w0; mem[1] = vecs[v].w1; tx_delay = vecs[v].delay;
      do_dump($sformatf("v%0d", v));
      check_seq($sformatf("v%0d", v), vecs[v].exp, vecs[v].cks, 1);
      for (int i = 0; i < 7; i++)
        if (i + 1 < log_c.size())
          chk($sformatf("v%0d_period%0d", v, i), 64'(log_c[i+1] - log_c[i]),
              ((i + 1) % 4 == 0) ? 64'(vecs[v].per_x) : 64'(vecs[v].per_in));
    end

    // Spurious start mid-dump and done during READ
    mem[0] = 32'h12345678; mem[1] = 32'hCAFEBABE; tx_delay = 3;
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mem_addr == 1) begin found = 1; break; end
    end
    chk("spur_read_found", 64'(found), 64'd1);
    spur_done = 1'b1;
    @(negedge clk); spur_done = 1'b0;
    wait_done(400, found);
    chk("spur_done_seen", 64'(found), 64'd1);
    repeat (10) @(negedge clk);
    chk("spur_no_restart", 64'(busy), 64'd0);
    chk("spur_done_count", 64'(done_cnt), 64'd1);
    check_seq("spur", 64'h12345678_CAFEBABE, 8'h38, 1);

    // Reset during WAIT of word 0 byte 2
    clear_logs();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    found = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx_start && tx_data == 8'h56) begin found = 1; break; end
    end
    chk("rstmid_byte2_found", 64'(found), 64'd1);
    @(negedge clk);
    chk("rstmid_busy_before", 64'(busy), 64'd1);
    #2 rst = 1'b1;
    #1;
    chk("rstmid_addr", 64'(mem_addr), 64'd0);
    chk("rstmid_tx_data", 64'(tx_data), 64'd0);
    chk("rstmid_tx_start", 64'(tx_start), 64'd0);
    chk("rstmid_busy", 64'(busy), 64'd0);
    chk("rstmid_done", 64'(done), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rstmid_idle_start", 64'(tx_start), 64'd0);
    do_dump("redump");
    check_seq("redump", 64'h12345678_CAFEBABE, 8'h38, 1);

    // Back-to-back dumps with start held high
    tx_delay = 2;
    clear_logs();
    found = 0;
    @(negedge clk); start = 1'b1;
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < 1000; i++) begin
        @(negedge clk);
        if (done) begin
          nd++;
          if (nd == 2) begin start = 1'b0; break; end
        end
      end
      chk("b2b_two_dones", 64'(nd), 64'd2);
    end
    repeat (5) @(negedge clk);
    chk("b2b_idle", 64'(busy), 64'd0);
    chk("b2b_done_count", 64'(done_cnt), 64'd2);
    check_seq("b2b", 64'h12345678_CAFEBABE, 8'h38, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
